ping_responder: RTL and testbench

- Synthesizable emulator of the far (sensor) end of the single-wire PING))) ultrasonic protocol.
- It detects a host trigger pulse on the shared sig line, waits a hold-off, then drives an echo pulse whose width encodes a programmed distance.
- It sits on the navigation board's US_Sensors test harness in place of a physical sensor, for hardware-in-loop checks of the ping host block and the navigation logic.
- All timing assumes the 50 MHz system clock.

---
 rtl/ping_responder_if.sv | 29 ++
 rtl/ping_responder.sv | 118 +++++++++++
 tb/tb_ping_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ping_responder_if.sv
// ping_responder_if: host-side status/control bundle for the PING))) sensor emulator.
// Optional status fields exist only when PING_STATUS_EN is defined.
interface ping_responder_if;
  logic [7:0] dist_in;
  logic       busy;
  logic       echo_active;
`ifdef PING_STATUS_EN
  logic [15:0] ping_count;
  logic        trig_err;
`endif
  modport master (
    output dist_in,
    input  busy,
    input  echo_active
`ifdef PING_STATUS_EN
    , input ping_count
    , input trig_err
`endif
  );
  modport slave (
    input  dist_in,
    output busy,
    output echo_active
`ifdef PING_STATUS_EN
    , output ping_count
    , output trig_err
`endif
  );
endinterface

// File: rtl/ping_responder.sv
// ping_responder: far-end emulator of the single-wire PING))) ultrasonic sensor.
// Define PING_STATUS_EN to add the ping_count / trig_err status outputs.
module ping_responder #(
  parameter int UNIT_CLKS = 7231,
  parameter int MIN_TRIG  = 100,
  parameter int MAX_TRIG  = 1000,
  parameter int HOLDOFF   = 40000,
  parameter int MIN_ECHO  = 5750,
  parameter int MAX_ECHO  = 925000,
  parameter int RECOVERY  = 10000
) (
  input  logic clk,
  input  logic reset,
  inout  wire  sig,
  ping_responder_if.slave bus
);
  localparam int UNIT = UNIT_CLKS + 1;
  localparam int WW = $clog2(MAX_TRIG + 1);
  localparam logic [WW-1:0] W_MIN = WW'(MIN_TRIG);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_TRIG);
  localparam logic [19:0] C_HOLD = 20'(HOLDOFF - 1);
  localparam logic [19:0] C_REC = 20'(RECOVERY);
  typedef enum logic [2:0] {IDLE, TRIG, WAITLOW, HOLD, ECHO, RECOV} st_t;
  st_t st, st_n;
  logic [1:0] rsync;
  logic rst_n;
  logic sig_m, sig_s, sig_d;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [19:0] cnt, cnt_n, elen, elen_n, elen_c;
  logic [21:0] raw;
  logic busy_r, busy_n, drv, drv_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rsync <= 2'b00;
    else rsync <= {rsync[0], 1'b1};
  assign rst_n = rsync[1];
  assign raw = 22'(bus.dist_in) * 22'(UNIT) + 22'(UNIT / 2);
  assign elen_c = raw < 22'(MIN_ECHO) ? 20'(MIN_ECHO) : raw > 22'(MAX_ECHO) ? 20'(MAX_ECHO) : raw[19:0];
  always_comb begin
    st_n = st;
    wcnt_n = wcnt;
    cnt_n = cnt;
    elen_n = elen;
    busy_n = busy_r;
    drv_n = drv;
    case (st)
      IDLE: if (sig_s && !sig_d) begin
        st_n = TRIG;
        wcnt_n = WW'(1);
      end
      TRIG: if (sig_s) begin
        if (wcnt == W_MAX) st_n = WAITLOW;
        else wcnt_n = wcnt + 1'b1;
      end else if (wcnt >= W_MIN) begin
        st_n = HOLD;
        busy_n = 1'b1;
        elen_n = elen_c;
        cnt_n = '0;
      end else st_n = IDLE;
      WAITLOW: if (!sig_s) st_n = IDLE;
      HOLD: if (cnt == C_HOLD) begin
        st_n = ECHO;
        drv_n = 1'b1;
        cnt_n = 20'd1;
      end else cnt_n = cnt + 20'd1;
      ECHO: if (cnt == elen) begin
        st_n = RECOV;
        drv_n = 1'b0;
        cnt_n = 20'd1;
      end else cnt_n = cnt + 20'd1;
      RECOV: if (cnt == C_REC) begin
        st_n = IDLE;
        busy_n = 1'b0;
        cnt_n = '0;
      end else cnt_n = cnt + 20'd1;
      default: st_n = IDLE;
    endcase
  end
  // sig synchronizer resets high so a line already high at reset release is not an edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      sig_m <= 1'b1;
      sig_s <= 1'b1;
      sig_d <= 1'b1;
      wcnt <= '0;
      cnt <= '0;
      elen <= '0;
      busy_r <= 1'b0;
      drv <= 1'b0;
    end else begin
      st <= st_n;
      sig_m <= sig;
      sig_s <= sig_m;
      sig_d <= sig_s;
      wcnt <= wcnt_n;
      cnt <= cnt_n;
      elen <= elen_n;
      busy_r <= busy_n;
      drv <= drv_n;
    end
  assign sig = drv ? 1'b1 : 1'bz;
  assign bus.busy = busy_r;
  assign bus.echo_active = drv;
`ifdef PING_STATUS_EN
  logic [15:0] pc;
  logic te;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= '0;
      te <= 1'b0;
    end else begin
      pc <= (st == TRIG && st_n == HOLD && pc != 16'hFFFF) ? pc + 16'd1 : pc;
      te <= te | (st == TRIG && (st_n == WAITLOW || st_n == IDLE));
    end
  assign bus.ping_count = pc;
  assign bus.trig_err = te;
`endif
endmodule

// File: tb/tb_ping_responder.sv
// tb_ping_responder: timeline model of trigger/hold/echo/recovery windows plus literal pins.
module tb_ping_responder;
  localparam int U = 15, MNT = 4, MXT = 20, HO = 50, MNE = 40, MXE = 1000, RC = 30;
  logic clk = 1'b0, reset = 1'b0, host = 1'b0;
  wire sig;
  int cyc = 0;
  int checks = 0, errors = 0;
  int t0 = -1000000, mlen = 0, bend = -1000000, mcount = 0, fall = 0;
  bit chk_en = 1'b0;
  int run = 0, lastw = 0, necho = 0, brise = 0, erise = 0;
  logic pb = 1'b0, pe = 1'b0;
  assign sig = host ? 1'b1 : 1'bz;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ping_responder_if bus();
  ping_responder #(.UNIT_CLKS(U), .MIN_TRIG(MNT), .MAX_TRIG(MXT), .HOLDOFF(HO),
    .MIN_ECHO(MNE), .MAX_ECHO(MXE), .RECOVERY(RC)) dut (.clk(clk), .reset(reset), .sig(sig), .bus(bus));
  function automatic int model_len(input int d);
    int r;
    r = d * (U + 1) + (U + 1) / 2;
    return r < MNE ? MNE : (r > MXE ? MXE : r);
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("busy", int'(bus.busy), int'(cyc >= t0 && cyc < bend));
    chk("echo_active", int'(bus.echo_active), int'(cyc >= t0 + HO && cyc < t0 + HO + mlen));
    if (cyc >= t0 + HO && cyc < t0 + HO + mlen) chk("sig_high", int'(sig), 1);
  end
  always @(negedge clk) begin
    if (!reset) run = 0;
    else begin
      if (bus.busy && !pb) brise = cyc;
      if (bus.echo_active && !pe) erise = cyc;
      if (bus.echo_active) run++;
      else if (run > 0) begin
        lastw = run;
        necho++;
        run = 0;
      end
    end
    pb = bus.busy;
    pe = bus.echo_active;
  end
  task automatic trig(input int w);
    int r;
    @(negedge clk);
    host = 1'b1;
    r = cyc;
    repeat (w) @(negedge clk);
    host = 1'b0;
    if (r + 3 > bend && w >= MNT && w <= MXT) begin
      fall = cyc;
      t0 = cyc + 3;
      mlen = model_len(int'(bus.dist_in));
      bend = t0 + HO + mlen + RC;
      mcount++;
    end
  endtask
  task automatic settle();
    while (cyc < bend + 5) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask
  task automatic ping(input int d, input int w);
    bus.dist_in = 8'(d);
    trig(w);
    settle();
  endtask
  initial begin
    int k;
    bus.dist_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_echo", int'(bus.echo_active), 0);
    chk("rst_sig", int'(sig), 0);
    host = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    host = 1'b0;
    repeat (30) @(negedge clk);
    chk("no_edge_at_release", necho, 0);
`ifdef PING_STATUS_EN
    chk("rst_count", int'(bus.ping_count), 0);
    chk("rst_err", int'(bus.trig_err), 0);
`endif
    ping(10, 10);
    chk("w_d10", lastw, 168);
    chk("fall_to_busy", brise - fall, 3);
    chk("busy_to_echo", erise - brise, 50);
    ping(0, 10);
    chk("w_d0_clamp", lastw, 40);
    ping(200, 10);
    chk("w_d200_clamp", lastw, 1000);
    chk("echo_n3", necho, 3);
    ping(3, 3);
    chk("short_rejected", necho, 3);
`ifdef PING_STATUS_EN
    chk("trig_err_short", int'(bus.trig_err), 1);
`endif
    ping(3, 4);
    chk("w_min_trig", lastw, 56);
    ping(4, 20);
    chk("w_max_trig", lastw, 72);
    ping(4, 30);
    chk("long_rejected", necho, 5);
    ping(10, 10);
    chk("after_long", lastw, 168);
    k = necho;
    bus.dist_in = 8'd10;
    trig(10);
    repeat (20) @(negedge clk);
    bus.dist_in = 8'd99;
    trig(5);
    while (cyc < t0 + HO + mlen + 3) @(negedge clk);
    trig(5);
    settle();
    chk("one_echo", necho - k, 1);
    chk("w_latched", lastw, 168);
`ifdef PING_STATUS_EN
    chk("count_model", int'(bus.ping_count), mcount);
`endif
    bus.dist_in = 8'd50;
    trig(10);
    k = 0;
    while (!bus.echo_active && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("echo_seen", int'(bus.echo_active), 1);
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b0;
    #1;
    chk("rst_mid_echo", int'(bus.echo_active), 0);
    chk("rst_mid_sig", int'(sig), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    t0 = -1000000;
    bend = -1000000;
    mlen = 0;
    mcount = 0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    ping(5, 10);
    chk("w_d5_after_rst", lastw, 88);
`ifdef PING_STATUS_EN
    chk("count_after_rst", int'(bus.ping_count), 1);
`endif
    for (int d = 1; d <= 3; d++) begin
      chk("busy_pre", int'(bus.busy), 0);
      ping(d, 10);
      chk("w_b2b", lastw, d == 3 ? 56 : 40);
    end
`ifdef PING_STATUS_EN
    chk("count_final", int'(bus.ping_count), 4);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
